// File: rtl/sqrt_sched_pkg.sv
// Shared definitions for the sqrt scheduler: FSM encoding, default sizing and an index-width helper.
package sqrt_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_IN_W  = 17;
  localparam int DEF_OUT_W = 13;
  localparam int DEF_LAT   = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A single requester still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_sched_if.sv
// Requester-side bus of the sqrt scheduler: radicand request handshake and one-hot result strobe.
interface sqrt_sched_if import sqrt_sched_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0][IN_W-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0]           rsp_valid;
  logic [OUT_W-1:0]           rsp_data;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sqrt_sched_rr_arbiter.sv
// Round-robin grant: picks the first valid requester at or after the pointer, purely combinational.
module rr_arbiter import sqrt_sched_pkg::*; #(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int PTR_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one external pipelined sqrt unit among N_REQ requesters with round-robin issue and flush/drain.
// Optional per-requester issue counters (stat_cnt) are built only when SQRT_SCHED_STATS_EN is defined.
//
// state    | meaning
// IDLE     | nothing issuing, waiting for a valid request
// RUN      | issuing one request per cycle, results retiring
// DRAIN    | flush held: no issue, waiting for in-flight results to retire
module sqrt_sched import sqrt_sched_pkg::*; #(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int IN_W  = DEF_IN_W,
  parameter  int OUT_W = DEF_OUT_W,
  parameter  int LAT   = DEF_LAT,
  localparam int TAG_W = idx_w(N_REQ),
  localparam int IF_W  = $clog2(LAT + 2)
) (
  input  logic             clk,
  input  logic             rst,
  sqrt_sched_if.slave      bus,
  input  logic             flush,
  output logic             flush_done,
  output logic [IN_W-1:0]  sqrt_in,
  input  logic [OUT_W-1:0] sqrt_out,
  output logic [IF_W-1:0]  in_flight
`ifdef SQRT_SCHED_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0] stat_cnt
`endif
);

  localparam logic [IF_W-1:0]  IF_ONE   = 1;
  localparam logic [TAG_W-1:0] TAG_ONE  = 1;
  localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant;
  logic             issue_en;
  logic             issue;
  logic             retire;

  // Stage 0 lines up with sqrt_in, stage LAT with sqrt_out.
  logic             pipe_v   [0:LAT];
  logic [TAG_W-1:0] pipe_tag [0:LAT];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign bus.req_ready = issue_en ? grant : '0;
  assign issue         = |(bus.req_valid & bus.req_ready);
  assign retire        = pipe_v[LAT];

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = TAG_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue_en   = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_IDLE: begin
        issue_en = !flush;
        if (|bus.req_valid && !flush) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        issue_en = !flush;
        if (flush)                                     state_nxt = ST_DRAIN;
        else if (!(|bus.req_valid) && in_flight == '0) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        flush_done = flush && (in_flight == '0);
        if (in_flight == '0 && !flush) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      sqrt_in       <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_valid <= '0;
      in_flight     <= '0;
      for (int k = 0; k <= LAT; k++) begin
        pipe_v[k]   <= 1'b0;
        pipe_tag[k] <= '0;
      end
    end else begin
      if (issue) begin
        sqrt_in <= bus.req_data[grant_idx];
        ptr     <= (grant_idx == TAG_LAST) ? '0 : grant_idx + TAG_ONE;
      end
      pipe_v[0]   <= issue;
      pipe_tag[0] <= grant_idx;
      for (int k = 1; k <= LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
      bus.rsp_valid <= '0;
      if (retire) begin
        bus.rsp_valid[pipe_tag[LAT]] <= 1'b1;
        bus.rsp_data                 <= sqrt_out;
      end
      case ({issue, retire})
        2'b10:   in_flight <= in_flight + IF_ONE;
        2'b01:   in_flight <= in_flight - IF_ONE;
        default: in_flight <= in_flight;
      endcase
    end
  end

`ifdef SQRT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (issue && grant[i] && stat_cnt[i] != 16'hFFFF) stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/sqrt_sched.md
SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one sqrt unit.
REQ-002 SHALL have parameter IN_W, default 17, radicand width.
REQ-003 SHALL have parameter OUT_W, default 13, root width (4 fractional bits).
REQ-004 SHALL have parameter LAT, default 13, sqrt pipeline latency in clock edges.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester radicand valid.
REQ-008 SHALL have port req_data  input  N_REQ x IN_W  per-requester radicand.
REQ-009 SHALL have port req_ready  output  N_REQ  one-hot grant.
REQ-010 SHALL have port flush  input  1  stop issuing and drain pipeline.
REQ-011 SHALL have port flush_done  output  1  pipeline empty after flush.
REQ-012 SHALL have port sqrt_in  output  IN_W  radicand to external sqrt.
REQ-013 SHALL have port sqrt_out  input  OUT_W  root from external sqrt.
REQ-014 SHALL have port rsp_valid  output  N_REQ  one-hot result strobe.
REQ-015 SHALL have port rsp_data  output  OUT_W  result, shared by all requesters.
REQ-016 SHALL have port in_flight  output  clog2(LAT+2)  outstanding operations.

Function
REQ-017 SHALL run FSM IDLE, RUN, DRAIN: IDLE->RUN on any req_valid with flush low; RUN->DRAIN on flush; RUN->IDLE when no req_valid and in_flight==0; DRAIN->IDLE when in_flight==0 and flush low.
REQ-018 SHALL assert req_ready only in IDLE/RUN, flush low, at most one bit, for the first valid requester at or after the round-robin pointer (combinational).
REQ-019 SHALL, on handshake (req_valid[i]&req_ready[i]) at edge E, load sqrt_in with req_data[i] and advance the pointer to i+1 mod N_REQ.
REQ-020 SHALL hold sqrt_in at its last value when no handshake occurs.
REQ-021 SHALL carry a valid bit and requester tag through an LAT-stage shift register aligned with sqrt_in.
REQ-022 SHALL register sqrt_out into rsp_data and pulse rsp_valid[tag] for one cycle at edge E+LAT+1; otherwise rsp_valid=0, rsp_data holds.
REQ-023 SHALL accept one handshake per cycle sustained; responses have no backpressure.
REQ-024 SHALL update in_flight as +1 on issue, -1 on retire, unchanged on simultaneous issue and retire.
REQ-025 SHALL assert flush_done in DRAIN when in_flight==0, held until flush deasserts.
REQ-026 SHALL keep the pointer unchanged when no handshake occurs; the pointer wraps from N_REQ-1 to 0.

Reset
REQ-027 SHALL on rst force FSM IDLE, pointer 0, tag pipe invalid, sqrt_in 0, rsp_data 0, rsp_valid 0, flush_done 0, in_flight 0; operations in flight are discarded.

Configuration
REQ-028 SHALL, with SQRT_SCHED_STATS_EN defined, add output stat_cnt (N_REQ x 16) of per-requester issue counts, saturating at 16'hFFFF, cleared by rst.
REQ-029 SHALL, without SQRT_SCHED_STATS_EN, omit stat_cnt and all counter logic.

Structure
REQ-030 SHALL place the FSM state enum and default parameter constants in package sqrt_sched_pkg.
REQ-031 SHALL implement grant selection in sub-module rr_arbiter (N_REQ, pointer in, grant out).

Verification
REQ-032 SHALL verify a single request: req 0 data 16900 at edge E -> rsp_valid[0] at E+14, rsp_data 2080.
REQ-033 SHALL verify round-robin: all four requesters valid continuously -> grants 0,1,2,3,0, one per cycle; results return in the same order, 14 cycles after each grant.
REQ-034 SHALL verify boundary values: data 0 -> 0; data 129600 -> 5760; in_flight peaks at 14 under saturated load.
REQ-035 SHALL verify flush: flush asserted after 5 issues -> req_ready 0, all 5 responses delivered, then flush_done=1.
REQ-036 SHALL verify reset mid-operation: rst with 6 in flight -> no rsp_valid afterwards, in_flight 0, pointer 0.
REQ-037 SHALL verify stats: with SQRT_SCHED_STATS_EN defined, 10 issues on requester 2 -> stat_cnt[2]=10, others 0.
